// File: rtl/ram_1p_req_adapter.sv
// ram_1p_req_adapter
//   Front-end for prim_ram_1p. Turns a valid/ready request stream into the
//   single-cycle req/write/addr/wdata/wmask strobes of the RAM. It captures the
//   RAM read data, which arrives one cycle after the request, into a small
//   response FIFO so the host can hold off responses without losing data. It
//   also expands the per-lane host write mask into the bit mask the RAM uses.
//
// Ports
//   clk_i, rst_i      clock (posedge) and asynchronous active-high reset
//   req_*             host request channel (valid/ready, write, addr, wdata, lane wmask)
//   rsp_*             host response channel (valid/ready, write flag, rdata)
//   ram_*             prim_ram_1p strobes; ram_rdata_i is valid one cycle after ram_req_o
//
// Parameters
//   Width            data width in bits
//   Depth            RAM words
//   DataBitsPerMask  data bits controlled by each host mask bit (must divide Width)
//   RspDepth         response FIFO entries (at least 2)
module ram_1p_req_adapter #(
    parameter int Width           = 39,
    parameter int Depth           = 128,
    parameter int DataBitsPerMask = 1,
    parameter int RspDepth        = 2,
    localparam int Aw             = $clog2(Depth),
    localparam int MaskW          = Width / DataBitsPerMask
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic [Aw-1:0]    req_addr_i,
    input  logic [Width-1:0] req_wdata_i,
    input  logic [MaskW-1:0] req_wmask_i,

    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_write_o,
    output logic [Width-1:0] rsp_rdata_o,

    output logic             ram_req_o,
    output logic             ram_write_o,
    output logic [Aw-1:0]    ram_addr_o,
    output logic [Width-1:0] ram_wdata_o,
    output logic [Width-1:0] ram_wmask_o,
    input  logic [Width-1:0] ram_rdata_i
);

    localparam int PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int CntW = $clog2(RspDepth + 1);
    localparam int OccW = CntW + 1;

    // Request in flight inside the RAM (read data or write ack due this cycle).
    logic            pending_reg;
    logic            pending_write_reg;

    logic [CntW-1:0] count_reg, count_next;
    logic [PtrW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PtrW-1:0] rd_ptr_reg, rd_ptr_next;

    logic [Width-1:0] fifo_rdata_mem [RspDepth];
    logic             fifo_write_mem [RspDepth];

    logic            fire;
    logic            push;
    logic            pop;
    logic            full;
    logic [OccW-1:0] occupancy;
    logic [Width-1:0] wmask_bits;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(RspDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    assign pop  = rsp_valid_o & rsp_ready_i;
    assign push = pending_reg;
    assign full = (count_reg == CntW'(RspDepth));

    // A slot is reserved for every request already in the RAM, so accepting a
    // request can never overflow the FIFO. Counting the pop of this cycle as a
    // free slot keeps one request per cycle flowing while the host drains.
    assign occupancy   = OccW'(count_reg) + OccW'(pending_reg) - OccW'(pop);
    assign req_ready_o = (occupancy < OccW'(RspDepth));
    assign fire        = req_valid_i & req_ready_o;

    assign ram_req_o   = fire;
    assign ram_write_o = req_write_i;
    assign ram_addr_o  = req_addr_i;
    assign ram_wdata_o = req_wdata_i;

    for (genvar gi = 0; gi < Width; gi++) begin : g_wmask
        assign wmask_bits[gi] = req_wmask_i[gi / DataBitsPerMask];
    end

    assign ram_wmask_o = req_write_i ? wmask_bits : '0;

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
        end
        if (pop) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
        end
        if (push && !pop) begin
            count_next = count_reg + CntW'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_reg       <= 1'b0;
            pending_write_reg <= 1'b0;
            count_reg         <= '0;
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
        end else begin
            pending_reg <= fire;
            if (fire) begin
                pending_write_reg <= req_write_i;
            end
            count_reg  <= count_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // Storage needs no reset: entries are only visible while count_reg covers
    // them, and the outputs below are gated by rsp_valid_o.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_rdata_mem[wr_ptr_reg] <= pending_write_reg ? '0 : ram_rdata_i;
            fifo_write_mem[wr_ptr_reg] <= pending_write_reg;
        end
    end

    assign rsp_valid_o = (count_reg != '0);
    assign rsp_write_o = rsp_valid_o & fifo_write_mem[rd_ptr_reg];
    assign rsp_rdata_o = rsp_valid_o ? fifo_rdata_mem[rd_ptr_reg] : '0;

    // The ready computation reserves a slot for every in-flight request.
    assert property (@(posedge clk_i) disable iff (rst_i) push |-> (!full || pop));

endmodule
